// File: rtl/cond_branch_unit.sv
// ---------------------------------------------------------------------------
// cond_branch_unit
//
// Resolves conditional branches against the comparator flags {N,Z,C,V}.
// A branch request is accepted in IDLE. If the flags are valid (the stored
// flags are fresh, or new flags arrive in the same cycle), the condition is
// evaluated at once and the result is held in HOLD. Otherwise the request
// is parked in WAIT_FLAGS until the next flag update arrives. The result is
// held in HOLD until the consumer takes it.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   cmp_issue   in   1  a compare was issued; the stored flags become stale
//   flag_valid  in   1  flag carries a new comparator result this cycle
//   flag        in   4  comparator flags {N,Z,C,V}
//   br_valid    in   1  branch request present
//   br_cond     in   4  condition code
//   br_target   in  32  branch target address
//   br_ready    out  1  request accepted when high together with br_valid
//   out_valid   out  1  resolution result available
//   out_taken   out  1  condition evaluated true
//   out_target  out 32  target of the resolved request
//   out_ready   in   1  consumer accepts the result
// ---------------------------------------------------------------------------
module cond_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmp_issue,
  input  logic        flag_valid,
  input  logic [3:0]  flag,
  input  logic        br_valid,
  input  logic [3:0]  br_cond,
  input  logic [31:0] br_target,
  output logic        br_ready,
  output logic        out_valid,
  output logic        out_taken,
  output logic [31:0] out_target,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FLAGS = 2'd1,
    S_HOLD       = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_fr;
  logic        r_fresh;
  logic [3:0]  r_cond;
  logic [31:0] r_target;
  logic        r_taken;
  logic [31:0] r_out_target;

  logic        w_load_result;
  logic        w_latch_req;
  logic [3:0]  w_eval_code;
  logic [3:0]  w_eval_flags;
  logic [31:0] w_result_target;
  logic        w_eval_taken;

  // Condition-code evaluation; flags are ordered {N,Z,C,V}.
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = c && !z;
      4'h9:    res = !c || z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = z || (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // ---- Next-state / evaluation select ----
  always_comb begin
    w_state_nxt     = r_state;
    w_load_result   = 1'b0;
    w_latch_req     = 1'b0;
    w_eval_code     = br_cond;
    w_eval_flags    = r_fr;
    w_result_target = br_target;
    case (r_state)
      S_IDLE: begin
        if (br_valid) begin
          if (r_fresh || flag_valid) begin
            // Same-cycle flags take priority over the stored copy.
            w_eval_flags  = flag_valid ? flag : r_fr;
            w_load_result = 1'b1;
            w_state_nxt   = S_HOLD;
          end else begin
            w_latch_req = 1'b1;
            w_state_nxt = S_WAIT_FLAGS;
          end
        end
      end
      S_WAIT_FLAGS: begin
        w_eval_code     = r_cond;
        w_eval_flags    = flag;
        w_result_target = r_target;
        if (flag_valid) begin
          w_load_result = 1'b1;
          w_state_nxt   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_eval_taken = eval_cond(w_eval_code, w_eval_flags);

  // ---- State, flag register and result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fr         <= 4'b0000;
      r_fresh      <= 1'b0;
      r_taken      <= 1'b0;
      r_out_target <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      // A flag update wins over a simultaneous compare issue.
      if (flag_valid) begin
        r_fr    <= flag;
        r_fresh <= 1'b1;
      end else if (cmp_issue) begin
        r_fresh <= 1'b0;
      end
      if (w_load_result) begin
        r_taken      <= w_eval_taken;
        r_out_target <= w_result_target;
      end
    end
  end

  // Parked request; only meaningful while in WAIT_FLAGS, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_latch_req) begin
      r_cond   <= br_cond;
      r_target <= br_target;
    end
  end

  // ---- Outputs ----
  assign br_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_HOLD);
  assign out_taken  = r_taken;
  assign out_target = r_out_target;

endmodule
